// File: rtl/regfile_pkg.sv
// Shared constants for the multi-read-port MIPS register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEFAULT  = 32;
   localparam int unsigned DEPTH_DEFAULT   = 32;
   localparam int unsigned REG_ZERO        = 0;
   localparam int unsigned REG_SP          = 29;
   localparam int unsigned SP_INIT_DEFAULT = 252;
   localparam int unsigned REG_RA          = 31;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One register-file read port: zero/bypass/storage selection feeding a held output register.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_mem_data,
   input  logic              i_mem_pend,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_pend
);

   logic [DATA_W-1:0] w_data;
   logic              w_pend;
   logic [DATA_W-1:0] r_data;
   logic              r_pend;

   // A same-edge write both forwards its data and retires the pending flag.
   always_comb begin
      w_data = i_mem_data;
      w_pend = i_mem_pend;
      if (i_addr == ADDR_W'(REG_ZERO)) begin
         w_data = '0;
         w_pend = 1'b0;
      end else if (i_wr_en && (i_wr_addr == i_addr)) begin
         w_data = i_wr_data;
         w_pend = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_data <= '0;
         r_pend <= 1'b0;
      end else if (i_en) begin
         r_data <= w_data;
         r_pend <= w_pend;
      end
   end

   assign o_data = r_data;
   assign o_pend = r_pend;

endmodule : regfile_read_port

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with hardwired r0, SP reset value and write bypass.
// Optional pending-operand scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter  int unsigned DATA_W   = DATA_W_DEFAULT,
   parameter  int unsigned DEPTH    = DEPTH_DEFAULT,
   parameter  int unsigned NUM_READ = 2,
   parameter  int unsigned SP_INDEX = REG_SP,
   parameter  int unsigned SP_INIT  = SP_INIT_DEFAULT,
   localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic [NUM_READ-1:0]        ReadEn,
   input  logic [NUM_READ*ADDR_W-1:0] ReadAddr,
   output logic [NUM_READ*DATA_W-1:0] ReadData,
   input  logic                       WriteEn,
   input  logic [ADDR_W-1:0]          WriteAddr,
   input  logic [DATA_W-1:0]          WriteData,
   input  logic                       AllocEn,
   input  logic [ADDR_W-1:0]          AllocAddr,
   output logic [NUM_READ-1:0]        ReadPending
);

   localparam bit SP_VALID = (SP_INDEX != 0) && (SP_INDEX < DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_ok;
   logic [DEPTH-1:0]  w_pending;

   assign w_wr_ok = WriteEn && (WriteAddr != ADDR_W'(REG_ZERO));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= (SP_VALID && (i == int'(SP_INDEX))) ? DATA_W'(SP_INIT) : '0;
         end
      end else if (w_wr_ok) begin
         r_mem[WriteAddr] <= WriteData;
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] r_pending;
   logic             w_alloc_ok;

   assign w_alloc_ok = AllocEn && (AllocAddr != ADDR_W'(REG_ZERO));

   // Alloc is applied last so a same-edge alloc beats the retiring write.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_pending <= '0;
      end else begin
         if (w_wr_ok)    r_pending[WriteAddr] <= 1'b0;
         if (w_alloc_ok) r_pending[AllocAddr] <= 1'b1;
      end
   end

   assign w_pending = r_pending;
`else
   logic w_unused_alloc;

   assign w_pending      = '0;
   assign w_unused_alloc = &{1'b0, AllocEn, AllocAddr};
`endif

   for (genvar g = 0; g < int'(NUM_READ); g++) begin : g_port
      logic [ADDR_W-1:0] w_addr;

      assign w_addr = ReadAddr[g*ADDR_W +: ADDR_W];

      regfile_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_port (
         .Clk        (Clk),
         .Rst        (Rst),
         .i_en       (ReadEn[g]),
         .i_addr     (w_addr),
         .i_mem_data (r_mem[w_addr]),
         .i_mem_pend (w_pending[w_addr]),
         .i_wr_en    (WriteEn),
         .i_wr_addr  (WriteAddr),
         .i_wr_data  (WriteData),
         .o_data     (ReadData[g*DATA_W +: DATA_W]),
         .o_pend     (ReadPending[g])
      );
   end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp at the default 32x32, two-read-port configuration.
module tb_reg_file_mp;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned DEPTH    = 32;
   localparam int unsigned NUM_READ = 2;
   localparam int unsigned ADDR_W   = 5;
`ifdef REGFILE_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic                       Clk;
   logic                       Rst;
   logic [NUM_READ-1:0]        ReadEn;
   logic [NUM_READ*ADDR_W-1:0] ReadAddr;
   logic [NUM_READ*DATA_W-1:0] ReadData;
   logic                       WriteEn;
   logic [ADDR_W-1:0]          WriteAddr;
   logic [DATA_W-1:0]          WriteData;
   logic                       AllocEn;
   logic [ADDR_W-1:0]          AllocAddr;
   logic [NUM_READ-1:0]        ReadPending;

   int n_tests = 0;
   int n_fail  = 0;

   reg_file_mp #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .NUM_READ (NUM_READ),
      .SP_INDEX (29),
      .SP_INIT  (252)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .ReadEn      (ReadEn),
      .ReadAddr    (ReadAddr),
      .ReadData    (ReadData),
      .WriteEn     (WriteEn),
      .WriteAddr   (WriteAddr),
      .WriteData   (WriteData),
      .AllocEn     (AllocEn),
      .AllocAddr   (AllocAddr),
      .ReadPending (ReadPending)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      WriteEn = 1'b1; WriteAddr = a; WriteData = d;
      tick();
      WriteEn = 1'b0;
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] e0, e1;
      Rst = 1'b1; ReadEn = '0; ReadAddr = '0; WriteEn = 1'b0; WriteAddr = '0;
      WriteData = '0; AllocEn = 1'b0; AllocAddr = '0;
      #12;
      n_tests++;
      if (ReadData !== '0) begin
         n_fail++; $display("FAIL reset_rdata: got %h want 0", ReadData);
      end
      n_tests++;
      if (ReadPending !== '0) begin
         n_fail++; $display("FAIL reset_pending: got %b want 0", ReadPending);
      end
      @(negedge Clk);
      Rst = 1'b0;
      for (int r = 0; r < 32; r += 2) begin
         ReadEn = 2'b11;
         ReadAddr = {5'(r + 1), 5'(r)};
         tick();
         e0 = (r == 29) ? 32'd252 : 32'd0;
         e1 = (r + 1 == 29) ? 32'd252 : 32'd0;
         n_tests++;
         if (ReadData[31:0] !== e0) begin
            n_fail++; $display("FAIL reset_r%0d: got %h want %h", r, ReadData[31:0], e0);
         end
         n_tests++;
         if (ReadData[63:32] !== e1) begin
            n_fail++; $display("FAIL reset_r%0d: got %h want %h", r + 1, ReadData[63:32], e1);
         end
      end
      ReadEn = '0;
   endtask

   task automatic test_write_read();
      do_write(5'd8, 32'hDEADBEEF);
      ReadEn = 2'b01; ReadAddr = {5'd0, 5'd8};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadData[31:0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL wr_r8: got %h want deadbeef", ReadData[31:0]);
      end
      do_write(5'd0, 32'h1234);
      ReadEn = 2'b11; ReadAddr = {5'd0, 5'd0};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadData !== 64'h0) begin
         n_fail++; $display("FAIL wr_r0: got %h want 0", ReadData);
      end
   endtask

   task automatic test_bypass();
      WriteEn = 1'b1; WriteAddr = 5'd9; WriteData = 32'hA5A5A5A5;
      ReadEn = 2'b11; ReadAddr = {5'd9, 5'd9};
      tick();
      WriteEn = 1'b0; ReadEn = '0;
      n_tests++;
      if (ReadData !== {2{32'hA5A5A5A5}}) begin
         n_fail++; $display("FAIL bypass_r9: got %h want a5a5a5a5a5a5a5a5", ReadData);
      end
      ReadEn = 2'b01; ReadAddr = {5'd0, 5'd9};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadData[31:0] !== 32'hA5A5A5A5) begin
         n_fail++; $display("FAIL bypass_stored: got %h want a5a5a5a5", ReadData[31:0]);
      end
   endtask

   task automatic test_hold();
      ReadEn = 2'b10; ReadAddr = {5'd8, 5'd0};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadData[63:32] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL hold_load: got %h want deadbeef", ReadData[63:32]);
      end
      do_write(5'd8, 32'h1);
      ReadEn = 2'b01; ReadAddr = {5'd8, 5'd8};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadData[63:32] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL hold_port1: got %h want deadbeef", ReadData[63:32]);
      end
      n_tests++;
      if (ReadData[31:0] !== 32'h1) begin
         n_fail++; $display("FAIL hold_port0_new: got %h want 1", ReadData[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      do_write(5'd1, 32'h11111111);
      do_write(5'd2, 32'h22222222);
      do_write(5'd3, 32'h33333333);
      do_write(5'd4, 32'h44444444);
      ReadEn = 2'b11; ReadAddr = {5'd2, 5'd1};
      tick();
      n_tests++;
      if (ReadData !== 64'h22222222_11111111) begin
         n_fail++; $display("FAIL b2b_12: got %h want 2222222211111111", ReadData);
      end
      ReadAddr = {5'd3, 5'd4};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadData !== 64'h33333333_44444444) begin
         n_fail++; $display("FAIL b2b_43: got %h want 3333333344444444", ReadData);
      end
   endtask

   task automatic test_reset_midop();
      WriteEn = 1'b1; WriteAddr = 5'd10; WriteData = 32'h55;
      #2 Rst = 1'b1;
      #1;
      n_tests++;
      if (ReadData !== '0) begin
         n_fail++; $display("FAIL midrst_out: got %h want 0", ReadData);
      end
      tick();
      WriteEn = 1'b0;
      Rst = 1'b0;
      ReadEn = 2'b11; ReadAddr = {5'd29, 5'd10};
      tick();
      n_tests++;
      if (ReadData[31:0] !== 32'h0) begin
         n_fail++; $display("FAIL midrst_r10: got %h want 0", ReadData[31:0]);
      end
      n_tests++;
      if (ReadData[63:32] !== 32'd252) begin
         n_fail++; $display("FAIL midrst_r29: got %h want fc", ReadData[63:32]);
      end
      ReadAddr = {5'd0, 5'd8};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadData[31:0] !== 32'h0) begin
         n_fail++; $display("FAIL midrst_r8: got %h want 0", ReadData[31:0]);
      end
   endtask

   task automatic test_scoreboard();
      AllocEn = 1'b1; AllocAddr = 5'd12;
      ReadEn = 2'b01; ReadAddr = {5'd0, 5'd12};
      tick();
      AllocEn = 1'b0;
      n_tests++;
      if (ReadPending[0] !== 1'b0) begin
         n_fail++; $display("FAIL sb_same_alloc: got %b want 0", ReadPending[0]);
      end
      tick();
      n_tests++;
      if (ReadPending[0] !== SB) begin
         n_fail++; $display("FAIL sb_alloc: got %b want %b", ReadPending[0], SB);
      end
      WriteEn = 1'b1; WriteAddr = 5'd12; WriteData = 32'd7;
      tick();
      WriteEn = 1'b0;
      n_tests++;
      if ({ReadPending[0], ReadData[31:0]} !== {1'b0, 32'd7}) begin
         n_fail++; $display("FAIL sb_wr_bypass: got %b/%h want 0/7", ReadPending[0], ReadData[31:0]);
      end
      tick();
      n_tests++;
      if ({ReadPending[0], ReadData[31:0]} !== {1'b0, 32'd7}) begin
         n_fail++; $display("FAIL sb_cleared: got %b/%h want 0/7", ReadPending[0], ReadData[31:0]);
      end
      ReadEn = '0;
      AllocEn = 1'b1; AllocAddr = 5'd12;
      WriteEn = 1'b1; WriteAddr = 5'd12; WriteData = 32'd9;
      tick();
      AllocEn = 1'b0; WriteEn = 1'b0;
      ReadEn = 2'b10; ReadAddr = {5'd12, 5'd0};
      tick();
      n_tests++;
      if ({ReadPending[1], ReadData[63:32]} !== {SB, 32'd9}) begin
         n_fail++; $display("FAIL sb_set_wins: got %b/%h want %b/9", ReadPending[1], ReadData[63:32], SB);
      end
      AllocEn = 1'b1; AllocAddr = 5'd0;
      tick();
      AllocEn = 1'b0;
      ReadEn = 2'b11; ReadAddr = {5'd0, 5'd0};
      tick();
      ReadEn = '0;
      n_tests++;
      if (ReadPending !== 2'b00) begin
         n_fail++; $display("FAIL sb_r0: got %b want 00", ReadPending);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_hold();
      test_back_to_back();
      test_reset_midop();
      test_scoreboard();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_reg_file_mp
